// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the CPU/DMA memory arbiter.
//   owner_e     : which requester held the bus on the last granted cycle
//   ADDR_W_DFLT : default address width
//   DATA_W_DFLT : default data width
//   BCNT_W      : width of the DMA burst counter
package mem_arb_pkg;

   typedef enum logic [0:0] {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

   localparam int ADDR_W_DFLT = 16;
   localparam int DATA_W_DFLT = 8;
   localparam int BCNT_W      = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the CPU request port, the DMA request port and the
// MEMORY port of the arbiter.
//   slave  modport : the arbiter's view (requests and MEM_DOUT in; grants,
//                    read returns and the memory command out)
//   master modport : the environment's view (requesters plus memory)
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT,
   parameter int DATA_W = DATA_W_DFLT
) ();

   logic              CPU_REQ;
   logic [ADDR_W-1:0] CPU_ADDR;
   logic              CPU_WE;
   logic [DATA_W-1:0] CPU_WDATA;
   logic              CPU_RDY;
   logic              CPU_RVALID;
   logic [DATA_W-1:0] CPU_RDATA;

   logic              DMA_REQ;
   logic [ADDR_W-1:0] DMA_ADDR;
   logic              DMA_WE;
   logic [DATA_W-1:0] DMA_WDATA;
   logic              DMA_GNT;
   logic              DMA_RVALID;
   logic [DATA_W-1:0] DMA_RDATA;

   logic [ADDR_W-1:0] MEM_ADDR;
   logic              MEM_WE;
   logic [DATA_W-1:0] MEM_DIN;
   logic [DATA_W-1:0] MEM_DOUT;

   modport slave (
      input  CPU_REQ, CPU_ADDR, CPU_WE, CPU_WDATA,
      input  DMA_REQ, DMA_ADDR, DMA_WE, DMA_WDATA,
      input  MEM_DOUT,
      output CPU_RDY, CPU_RVALID, CPU_RDATA,
      output DMA_GNT, DMA_RVALID, DMA_RDATA,
      output MEM_ADDR, MEM_WE, MEM_DIN
   );

   modport master (
      output CPU_REQ, CPU_ADDR, CPU_WE, CPU_WDATA,
      output DMA_REQ, DMA_ADDR, DMA_WE, DMA_WDATA,
      output MEM_DOUT,
      input  CPU_RDY, CPU_RVALID, CPU_RDATA,
      input  DMA_GNT, DMA_RVALID, DMA_RDATA,
      input  MEM_ADDR, MEM_WE, MEM_DIN
   );

endinterface

// File: rtl/mem_arb_burst_cnt.sv
// mem_arb_burst_cnt: starvation guard for the memory arbiter. Counts DMA
// grants taken while the CPU is waiting and raises force_cpu once BURST_MAX
// of them have gone by, so the CPU gets the next slot.
//   CLK, R_N  : clock, asynchronous active-low reset
//   cpu_req   : CPU request pending
//   dma_req   : DMA request pending
//   dma_gnt   : DMA granted this cycle
//   force_cpu : give this cycle to the CPU regardless of DMA
module mem_arb_burst_cnt
   import mem_arb_pkg::*;
#(
   parameter int BURST_MAX = 4
) (
   input  logic CLK,
   input  logic R_N,
   input  logic cpu_req,
   input  logic dma_req,
   input  logic dma_gnt,
   output logic force_cpu
);

   localparam logic [BCNT_W-1:0] BMAX = BCNT_W'(BURST_MAX);
   localparam logic [BCNT_W-1:0] ONE  = {{(BCNT_W-1){1'b0}}, 1'b1};

   logic [BCNT_W-1:0] bcnt_r;

   // Force a CPU slot once the burst limit is reached with both sides requesting
   always_comb begin
      force_cpu = cpu_req & dma_req & (bcnt_r == BMAX);
   end

   // Burst counter: counts only while the CPU waits; a CPU slot or idle DMA clears it
   always_ff @(posedge CLK or negedge R_N) begin
      if (!R_N) begin
         bcnt_r <= {BCNT_W{1'b0}};
      end else if (!dma_req) begin
         bcnt_r <= {BCNT_W{1'b0}};
      end else if (dma_gnt) begin
         // With no CPU waiting the count freezes rather than clearing
         if (cpu_req && (bcnt_r != BMAX)) begin
            bcnt_r <= bcnt_r + ONE;
         end else begin
            bcnt_r <= bcnt_r;
         end
      end else begin
         // DMA requesting but not granted: this was the forced CPU slot
         bcnt_r <= {BCNT_W{1'b0}};
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port MEMORY between the 6502 core and a DMA
// requester. DMA steals cycles; the CPU is stalled (CPU_RDY low) when it loses.
// Reads return one cycle after the grant, tagged by CPU_RVALID / DMA_RVALID.
//   CLK, R_N  : clock, asynchronous active-low reset (also gates MEM_WE)
//   bus.slave : CPU port, DMA port and MEMORY port (see mem_arbiter_if)
// Build option: define MEM_ARB_STARVE_GUARD_EN to bound DMA bursts to
// BURST_MAX grants while the CPU waits; without it DMA has strict priority
// and BURST_MAX is ignored.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int BURST_MAX = 4,
   parameter int ADDR_W    = ADDR_W_DFLT,
   parameter int DATA_W    = DATA_W_DFLT
) (
   input logic          CLK,
   input logic          R_N,
   mem_arbiter_if.slave bus
);

   logic              force_cpu_s;
   logic              dma_gnt_s;
   logic              cpu_rdy_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic              mem_we_s;
   logic [DATA_W-1:0] mem_din_s;

   owner_e            own_r;
   logic [ADDR_W-1:0] last_addr_r;
   logic              rd_cpu_r;
   logic              rd_dma_r;

`ifdef MEM_ARB_STARVE_GUARD_EN
   mem_arb_burst_cnt #(
      .BURST_MAX (BURST_MAX)
   ) u_burst_cnt (
      .CLK       (CLK),
      .R_N       (R_N),
      .cpu_req   (bus.CPU_REQ),
      .dma_req   (bus.DMA_REQ),
      .dma_gnt   (dma_gnt_s),
      .force_cpu (force_cpu_s)
   );
`else
   assign force_cpu_s = 1'b0;
`endif

   // Grant decision; R_N gating keeps every grant (and so MEM_WE) low in reset
   always_comb begin
      dma_gnt_s = R_N & bus.DMA_REQ & ~force_cpu_s;
      cpu_rdy_s = R_N & bus.CPU_REQ & ~dma_gnt_s;
   end

   // Memory command mux; idle cycles park the address and never write
   always_comb begin
      mem_addr_s = last_addr_r;
      mem_we_s   = 1'b0;
      mem_din_s  = bus.CPU_WDATA;
      if (dma_gnt_s) begin
         mem_addr_s = bus.DMA_ADDR;
         mem_we_s   = bus.DMA_WE;
         mem_din_s  = bus.DMA_WDATA;
      end else if (cpu_rdy_s) begin
         mem_addr_s = bus.CPU_ADDR;
         mem_we_s   = bus.CPU_WE;
         mem_din_s  = bus.CPU_WDATA;
      end else begin
         // Keep the write-data bus on the last owner to avoid needless toggling
         if (own_r == OWN_DMA) begin
            mem_din_s = bus.DMA_WDATA;
         end else begin
            mem_din_s = bus.CPU_WDATA;
         end
      end
   end

   // Owner FSM, parked address and read-return tags
   always_ff @(posedge CLK or negedge R_N) begin
      if (!R_N) begin
         own_r       <= OWN_CPU;
         last_addr_r <= {ADDR_W{1'b0}};
         rd_cpu_r    <= 1'b0;
         rd_dma_r    <= 1'b0;
      end else begin
         rd_cpu_r <= cpu_rdy_s & ~bus.CPU_WE;
         rd_dma_r <= dma_gnt_s & ~bus.DMA_WE;
         case (own_r)
            OWN_CPU, OWN_DMA: begin
               if (dma_gnt_s) begin
                  own_r       <= OWN_DMA;
                  last_addr_r <= bus.DMA_ADDR;
               end else if (cpu_rdy_s) begin
                  own_r       <= OWN_CPU;
                  last_addr_r <= bus.CPU_ADDR;
               end else begin
                  own_r       <= own_r;
                  last_addr_r <= last_addr_r;
               end
            end
            default: begin
               own_r       <= OWN_CPU;
               last_addr_r <= last_addr_r;
            end
         endcase
      end
   end

   assign bus.CPU_RDY    = cpu_rdy_s;
   assign bus.DMA_GNT    = dma_gnt_s;
   assign bus.MEM_ADDR   = mem_addr_s;
   assign bus.MEM_WE     = mem_we_s;
   assign bus.MEM_DIN    = mem_din_s;
   assign bus.CPU_RVALID = rd_cpu_r;
   assign bus.DMA_RVALID = rd_dma_r;
   // Both requesters see the raw memory output and qualify it with RVALID
   assign bus.CPU_RDATA  = bus.MEM_DOUT;
   assign bus.DMA_RDATA  = bus.MEM_DOUT;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. A memory behaviour lives in
// the bench, a reference model checks every cycle on the falling edge, and
// directed steps pin hand-computed values. Works with or without
// MEM_ARB_STARVE_GUARD_EN defined.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW   = 16;
   localparam int DW   = 8;
   localparam int BMAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic CLK = 1'b0;
   logic R_N = 1'b0;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(
      .BURST_MAX (BMAX),
      .ADDR_W    (AW),
      .DATA_W    (DW)
   ) dut (
      .CLK (CLK),
      .R_N (R_N),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Power-up contents of the memory where nothing has been written yet
   function automatic logic [7:0] init_byte(input logic [15:0] a);
      return a[15:8] ^ a[7:0] ^ 8'h8F;
   endfunction

   // ---------------- memory behaviour (environment) ----------------
   bit [7:0] env_mem [0:65535];
   bit       env_wr  [0:65535];

   always @(posedge CLK) begin
      bus.MEM_DOUT <= env_wr[bus.MEM_ADDR] ? env_mem[bus.MEM_ADDR] : init_byte(bus.MEM_ADDR);
      if (bus.MEM_WE) begin
         env_mem[bus.MEM_ADDR] <= bus.MEM_DIN;
         env_wr[bus.MEM_ADDR]  <= 1'b1;
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   bit [7:0]  ref_mem [0:65535];
   bit        ref_wr  [0:65535];
   int        streak  = 0;       // DMA grants taken while the CPU was waiting
   logic [15:0] m_last = 16'h0000;
   bit        m_rdc = 1'b0, m_rdd = 1'b0;
   logic [7:0] m_rdata = 8'h00;
   bit        cg, dg, ewe;
   logic [15:0] eaddr, ra;
   logic [7:0] edin;

   initial begin
      forever begin
         @(negedge CLK);
         dg = R_N && bus.DMA_REQ && !(GUARD && bus.CPU_REQ && (streak >= BMAX));
         cg = R_N && bus.CPU_REQ && !dg;
         ewe   = (dg && bus.DMA_WE) || (cg && bus.CPU_WE);
         eaddr = !R_N ? 16'h0000 : dg ? bus.DMA_ADDR : cg ? bus.CPU_ADDR : m_last;
         edin  = dg ? bus.DMA_WDATA : bus.CPU_WDATA;
         chk("m_dma_gnt", bus.DMA_GNT, dg);
         chk("m_cpu_rdy", bus.CPU_RDY, cg);
         chk("m_mem_we", bus.MEM_WE, ewe);
         chk("m_mem_addr", bus.MEM_ADDR, eaddr);
         if (ewe) chk("m_mem_din", bus.MEM_DIN, edin);
         chk("m_cpu_rvalid", bus.CPU_RVALID, R_N && m_rdc);
         chk("m_dma_rvalid", bus.DMA_RVALID, R_N && m_rdd);
         if (R_N && m_rdc) chk("m_cpu_rdata", bus.CPU_RDATA, m_rdata);
         if (R_N && m_rdd) chk("m_dma_rdata", bus.DMA_RDATA, m_rdata);
         // advance to the state seen after the next rising edge
         if (!R_N) begin
            streak = 0;
            m_last = 16'h0000;
            m_rdc  = 1'b0;
            m_rdd  = 1'b0;
         end else begin
            m_rdc = cg && !bus.CPU_WE;
            m_rdd = dg && !bus.DMA_WE;
            if (dg || cg) begin
               ra     = dg ? bus.DMA_ADDR : bus.CPU_ADDR;
               m_last = ra;
               if (ewe) begin
                  ref_mem[ra] = edin;
                  ref_wr[ra]  = 1'b1;
               end else begin
                  m_rdata = ref_wr[ra] ? ref_mem[ra] : init_byte(ra);
               end
            end
            if (cg || !bus.DMA_REQ) streak = 0;
            else if (dg && bus.CPU_REQ && streak < BMAX) streak = streak + 1;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_cpu(input logic req, input logic [15:0] a, input logic we, input logic [7:0] d);
      bus.CPU_REQ = req; bus.CPU_ADDR = a; bus.CPU_WE = we; bus.CPU_WDATA = d;
   endtask

   task automatic set_dma(input logic req, input logic [15:0] a, input logic we, input logic [7:0] d);
      bus.DMA_REQ = req; bus.DMA_ADDR = a; bus.DMA_WE = we; bus.DMA_WDATA = d;
   endtask

   // Runs n cycles with current inputs and compares the grant letters to pat
   task automatic run_pattern(input string tag, input string pat, input int n);
      byte got;
      byte want;
      for (int i = 0; i < n; i++) begin
         if (i > 0) cyc();
         @(negedge CLK);
         got  = bus.DMA_GNT ? "D" : (bus.CPU_RDY ? "C" : "-");
         want = pat[i];
         chk($sformatf("%s_%0d", tag, i), got, want);
         if (tag == "burst" && i == 1) begin
            chk("burst_dma_rvalid", bus.DMA_RVALID, 1'b1);
            chk("burst_dma_rdata", bus.DMA_RDATA, 8'h8B);
         end
      end
   endtask

   initial begin
      set_cpu(1'b1, 16'h1234, 1'b0, 8'h00);
      set_dma(1'b1, 16'h0300, 1'b1, 8'h77);
      R_N = 1'b0;

      // Reset held with both requesting
      repeat (3) @(negedge CLK);
      chk("rst_cpu_rdy", bus.CPU_RDY, 1'b0);
      chk("rst_dma_gnt", bus.DMA_GNT, 1'b0);
      chk("rst_mem_we", bus.MEM_WE, 1'b0);
      chk("rst_mem_addr", bus.MEM_ADDR, 16'h0000);
      chk("rst_cpu_rvalid", bus.CPU_RVALID, 1'b0);
      chk("rst_dma_rvalid", bus.DMA_RVALID, 1'b0);

      // Release: DMA wins the first cycle
      cyc(); R_N = 1'b1;
      @(negedge CLK);
      chk("rel_dma_first", bus.DMA_GNT, 1'b1);
      chk("rel_cpu_wait", bus.CPU_RDY, 1'b0);
      chk("rel_mem_we", bus.MEM_WE, 1'b1);
      chk("rel_mem_din", bus.MEM_DIN, 8'h77);

      // Idle: no write, address parked on last grant
      cyc(); set_cpu(1'b0, 16'h1234, 1'b1, 8'hEE); set_dma(1'b0, 16'h0999, 1'b1, 8'hEE);
      @(negedge CLK);
      chk("idle_we", bus.MEM_WE, 1'b0);
      chk("idle_addr_hold", bus.MEM_ADDR, 16'h0300);

      // CPU-only read of 0x1234
      cyc(); set_cpu(1'b1, 16'h1234, 1'b0, 8'h00);
      @(negedge CLK);
      chk("cpu_rd_rdy", bus.CPU_RDY, 1'b1);
      chk("cpu_rd_addr", bus.MEM_ADDR, 16'h1234);
      cyc(); set_cpu(1'b0, 16'h1234, 1'b0, 8'h00);
      @(negedge CLK);
      chk("cpu_rd_rvalid", bus.CPU_RVALID, 1'b1);
      chk("cpu_rd_data", bus.CPU_RDATA, 8'hA9);
      chk("cpu_rd_dma_rvalid", bus.DMA_RVALID, 1'b0);

      // DMA write 0x5C to 0x0200 with CPU waiting on the same address
      cyc(); set_dma(1'b1, 16'h0200, 1'b1, 8'h5C); set_cpu(1'b1, 16'h0200, 1'b0, 8'h00);
      @(negedge CLK);
      chk("dw_dma_gnt", bus.DMA_GNT, 1'b1);
      chk("dw_cpu_rdy", bus.CPU_RDY, 1'b0);
      chk("dw_mem_we", bus.MEM_WE, 1'b1);
      chk("dw_mem_din", bus.MEM_DIN, 8'h5C);
      cyc(); bus.DMA_REQ = 1'b0;
      @(negedge CLK);
      chk("rb_cpu_rdy", bus.CPU_RDY, 1'b1);
      cyc(); bus.CPU_REQ = 1'b0;
      @(negedge CLK);
      chk("rb_cpu_rvalid", bus.CPU_RVALID, 1'b1);
      chk("rb_cpu_rdata", bus.CPU_RDATA, 8'h5C);

      // Both requesting for 12 cycles
      cyc(); set_dma(1'b1, 16'h0400, 1'b0, 8'h00); set_cpu(1'b1, 16'h0500, 1'b0, 8'h00);
      run_pattern("burst", GUARD ? "DDDDCDDDDCDD" : "DDDDDDDDDDDD", 12);

      // Burst limit reached, CPU drops out, then returns
      cyc(); bus.DMA_REQ = 1'b0; bus.CPU_REQ = 1'b0;
      cyc(); bus.DMA_REQ = 1'b1; bus.CPU_REQ = 1'b1;
      run_pattern("fill", "DDDD", 4);
      cyc(); bus.CPU_REQ = 1'b0;
      @(negedge CLK);
      chk("drop_cpu_dma_gnt", bus.DMA_GNT, 1'b1);
      cyc(); bus.CPU_REQ = 1'b1;
      @(negedge CLK);
      chk("resume_cpu_rdy", bus.CPU_RDY, GUARD);
      chk("resume_dma_gnt", bus.DMA_GNT, !GUARD);

      // Reset asserted during a granted CPU read
      cyc(); bus.DMA_REQ = 1'b0; bus.CPU_REQ = 1'b0;
      cyc(); set_cpu(1'b1, 16'h1234, 1'b0, 8'h00);
      #1;
      chk("mid_grant", bus.CPU_RDY, 1'b1);
      #1;
      R_N = 1'b0;
      @(negedge CLK);
      chk("mid_rst_rdy", bus.CPU_RDY, 1'b0);
      chk("mid_rst_addr", bus.MEM_ADDR, 16'h0000);
      cyc(); R_N = 1'b1; bus.CPU_REQ = 1'b0;
      @(negedge CLK);
      chk("mid_rvalid_drop", bus.CPU_RVALID, 1'b0);
      cyc(); set_dma(1'b1, 16'h0400, 1'b0, 8'h00); set_cpu(1'b1, 16'h0500, 1'b0, 8'h00);
      run_pattern("after_rst", GUARD ? "DDDDC" : "DDDDD", 5);

      cyc(); bus.DMA_REQ = 1'b0; bus.CPU_REQ = 1'b0;
      repeat (2) @(negedge CLK);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
